i2c_sensor_poller: RTL

Command-level sequencer in front of the I2C master. After enable it reads the sensor ID register once and checks it. It then issues periodic two-byte temperature register reads, retrying on NACK. The latest raw temperature word is presented to the rest of the design with a one-cycle valid strobe.

---
 rtl/i2c_pkg.sv | 42 ++++
 rtl/i2c_interval_timer.sv | 45 ++++
 rtl/i2c_sensor_poller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C sensor poller and its helpers:
//   - poll_state_t   : sequencer states
//   - retry_target_t : which command a GAP period leads back to
//   - default device / register constants for the temperature sensor
//   - cmd_len encodings handed to the I2C master
//   - retry_inc      : saturating increment for the 4-bit retry counter
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ID_REQ    = 3'd1,
    ID_WAIT   = 3'd2,
    GAP       = 3'd3,
    TEMP_REQ  = 3'd4,
    TEMP_WAIT = 3'd5,
    FAULT     = 3'd6
  } poll_state_t;

  typedef enum logic {
    TARGET_ID   = 1'b0,
    TARGET_TEMP = 1'b1
  } retry_target_t;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h4B;
  localparam logic [7:0] DEFAULT_ID_REG   = 8'h0B;
  localparam logic [7:0] DEFAULT_TEMP_REG = 8'h00;
  localparam logic [7:0] DEFAULT_EXP_ID   = 8'hCB;

  localparam logic [1:0] CMD_LEN_NONE = 2'd0;
  localparam logic [1:0] CMD_LEN_ONE  = 2'd1;
  localparam logic [1:0] CMD_LEN_TWO  = 2'd2;

  // Counter sticks at all-ones so a long NACK streak can never wrap back
  // below the retry limit.
  function automatic logic [3:0] retry_inc(input logic [3:0] count);
    return (count == 4'hF) ? count : count + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_interval_timer.sv
// ---------------------------------------------------------------------------
// i2c_interval_timer
// Loadable down-counter that paces the poller's GAP state.
// Ports:
//   clk   in  : system clock
//   rst_n in  : asynchronous active-low reset
//   load  in  : (re)start the interval, counter takes POLL_CYCLES-1
//   tc    out : one-cycle terminal-count pulse, POLL_CYCLES cycles after load
// ---------------------------------------------------------------------------
module i2c_interval_timer #(
  parameter int unsigned POLL_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  localparam int unsigned CNT_W = $clog2(POLL_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(POLL_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic             active_q;

  // The active flag keeps tc a single pulse: once the count reaches zero the
  // timer idles until the next load instead of reporting zero forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      count_q  <= LOAD_VAL;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_q <= 1'b0;
      end else begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign tc = active_q && (count_q == '0);

endmodule

// File: rtl/i2c_sensor_poller.sv
// ---------------------------------------------------------------------------
// i2c_sensor_poller
// Command-level sequencer in front of an I2C master. After enable it reads
// the sensor ID register once and checks it, then polls the two-byte
// temperature register every POLL_CYCLES clocks, retrying on NACK.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : run the polling sequence while high
//   cmd_valid/cmd_ready : command handshake towards the I2C master
//   cmd_dev_addr        : 7-bit device address of the command
//   cmd_reg_addr        : register pointer written before the repeated start
//   cmd_len             : bytes to read (1 or 2)
//   rsp_valid/rsp_nack  : transaction-finished pulse and its NACK qualifier
//   rsp_data            : read data, first byte in [15:8]
//   temp_raw/temp_valid : last good temperature word and its update strobe
//   id_ok               : ID check passed since enable
//   busy                : a command is outstanding (REQ or WAIT state)
//   fault               : sticky fault, cleared by dropping enable
// ---------------------------------------------------------------------------
module i2c_sensor_poller
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter logic [7:0]  ID_REG      = DEFAULT_ID_REG,
  parameter logic [7:0]  TEMP_REG    = DEFAULT_TEMP_REG,
  parameter logic [7:0]  EXP_ID      = DEFAULT_EXP_ID,
  parameter int unsigned POLL_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_dev_addr,
  output logic [7:0]  cmd_reg_addr,
  output logic [1:0]  cmd_len,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [15:0] rsp_data,
  output logic [15:0] temp_raw,
  output logic        temp_valid,
  output logic        id_ok,
  output logic        busy,
  output logic        fault
);

  localparam logic [3:0] MAX_RETRY_CNT = 4'(MAX_RETRY);

  poll_state_t   state_q, state_d;
  retry_target_t target_q, target_d;
  logic [3:0]    retry_q, retry_d;
  logic [3:0]    retry_bumped;
  logic          retry_exhausted;
  logic          cmd_fire;
  logic          id_match;
  logic          gap_load;
  logic          gap_tc;

  logic          cmd_valid_d;
  logic [6:0]    cmd_dev_addr_d;
  logic [7:0]    cmd_reg_addr_d;
  logic [1:0]    cmd_len_d;
  logic [15:0]   temp_raw_d;
  logic          temp_valid_d;
  logic          id_ok_d;

  assign cmd_fire        = cmd_valid && cmd_ready;
  assign id_match        = (rsp_data[15:8] == EXP_ID);
  assign retry_bumped    = retry_inc(retry_q);
  assign retry_exhausted = (retry_bumped >= MAX_RETRY_CNT);

  // Spacing between polls and between retries; loaded as GAP is entered.
  i2c_interval_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_gap_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (gap_load),
    .tc   (gap_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Once a command has been issued it always runs to its
  // response, so enable is only looked at in IDLE, GAP and FAULT, and again
  // when the response arrives to decide between IDLE and the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = ID_REQ;
      end
      ID_REQ: begin
        if (cmd_fire) state_d = ID_WAIT;
      end
      ID_WAIT: begin
        if (rsp_valid) begin
          if (!enable)              state_d = IDLE;
          else if (rsp_nack)        state_d = retry_exhausted ? FAULT : GAP;
          else if (id_match)        state_d = TEMP_REQ;
          else                      state_d = FAULT;
        end
      end
      TEMP_REQ: begin
        if (cmd_fire) state_d = TEMP_WAIT;
      end
      TEMP_WAIT: begin
        if (rsp_valid) begin
          if (!enable)              state_d = IDLE;
          else if (rsp_nack)        state_d = retry_exhausted ? FAULT : GAP;
          else                      state_d = GAP;
        end
      end
      GAP: begin
        if (!enable)                state_d = IDLE;
        else if (gap_tc)            state_d = (target_q == TARGET_ID) ? ID_REQ : TEMP_REQ;
      end
      FAULT: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: combinational status flags plus the next values of the
  // registered command, temperature and bookkeeping outputs. cmd_valid is
  // requested for every REQ cycle except the handshake cycle, so it rises one
  // cycle after entering REQ and is low right after the accepting edge. The
  // command fields are rewritten with the same constant on every REQ cycle,
  // which keeps them stable while cmd_valid is high.
  always_comb begin
    busy           = 1'b0;
    fault          = 1'b0;
    gap_load       = (state_d == GAP) && (state_q != GAP);
    retry_d        = retry_q;
    target_d       = target_q;
    cmd_valid_d    = 1'b0;
    cmd_dev_addr_d = cmd_dev_addr;
    cmd_reg_addr_d = cmd_reg_addr;
    cmd_len_d      = cmd_len;
    temp_raw_d     = temp_raw;
    temp_valid_d   = 1'b0;
    id_ok_d        = id_ok;

    case (state_q)
      IDLE: begin
        retry_d = 4'd0;
      end
      ID_REQ: begin
        busy           = 1'b1;
        cmd_valid_d    = !cmd_fire;
        cmd_dev_addr_d = DEV_ADDR;
        cmd_reg_addr_d = ID_REG;
        cmd_len_d      = CMD_LEN_ONE;
      end
      ID_WAIT: begin
        busy = 1'b1;
        if (rsp_valid) begin
          if (rsp_nack) begin
            retry_d  = retry_bumped;
            target_d = TARGET_ID;
          end else if (id_match) begin
            id_ok_d = 1'b1;
            retry_d = 4'd0;
          end
        end
      end
      TEMP_REQ: begin
        busy           = 1'b1;
        cmd_valid_d    = !cmd_fire;
        cmd_dev_addr_d = DEV_ADDR;
        cmd_reg_addr_d = TEMP_REG;
        cmd_len_d      = CMD_LEN_TWO;
      end
      TEMP_WAIT: begin
        busy = 1'b1;
        if (rsp_valid) begin
          target_d = TARGET_TEMP;
          if (rsp_nack) begin
            retry_d = retry_bumped;
          end else begin
            temp_raw_d   = rsp_data;
            temp_valid_d = 1'b1;
            retry_d      = 4'd0;
          end
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase

    // Every return to IDLE drops the ID qualification, including a stop
    // requested while a command was still in flight.
    if (state_d == IDLE) id_ok_d = 1'b0;
  end

  // Registered outputs and retry bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid    <= 1'b0;
      cmd_dev_addr <= 7'd0;
      cmd_reg_addr <= 8'd0;
      cmd_len      <= CMD_LEN_NONE;
      temp_raw     <= 16'd0;
      temp_valid   <= 1'b0;
      id_ok        <= 1'b0;
      retry_q      <= 4'd0;
      target_q     <= TARGET_ID;
    end else begin
      cmd_valid    <= cmd_valid_d;
      cmd_dev_addr <= cmd_dev_addr_d;
      cmd_reg_addr <= cmd_reg_addr_d;
      cmd_len      <= cmd_len_d;
      temp_raw     <= temp_raw_d;
      temp_valid   <= temp_valid_d;
      id_ok        <= id_ok_d;
      retry_q      <= retry_d;
      target_q     <= target_d;
    end
  end

endmodule
